// File: rtl/action_table_arbiter.sv
// action_table_arbiter
//   Owns the single-port action RAM. Pipeline lookups and queued MMIO
//   config writes share the port. Lookups win by default, and a starvation
//   counter forces a queued write through after STARVE_MAX consecutive
//   lookup grants. Misses are answered from the default action register,
//   which is snapshotted at lookup grant.
//   Optional feature: define ACTION_ARB_STATS_EN to add the 32-bit
//   lookup/write grant counters o_stat_lookups and o_stat_writes.
module action_table_arbiter #(
    parameter int ENTRIES    = 16,
    parameter int ACTION_W   = 64,
    parameter int IDX_W      = $clog2(ENTRIES),
    parameter int WQ_DEPTH   = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                i_clk,
    input  logic                i_resetn,
    input  logic                i_lk_valid,
    output logic                o_lk_ready,
    input  logic [IDX_W-1:0]    i_lk_idx,
    input  logic                i_lk_hit,
    output logic                o_rsp_valid,
    output logic [ACTION_W-1:0] o_rsp_action,
    input  logic                i_cfg_wr_en,
    input  logic [IDX_W-1:0]    i_cfg_wr_addr,
    input  logic [ACTION_W-1:0] i_cfg_wr_data,
    input  logic                i_cfg_wr_default,
    input  logic [ACTION_W-1:0] i_cfg_default_data,
    output logic                o_cfg_wq_full,
    output logic                o_cfg_ovf,
    input  logic                i_cfg_ovf_clr,
    output logic                o_ram_en,
    output logic                o_ram_we,
    output logic [IDX_W-1:0]    o_ram_addr,
    output logic [ACTION_W-1:0] o_ram_wdata,
    input  logic [ACTION_W-1:0] i_ram_rdata
`ifdef ACTION_ARB_STATS_EN
    ,
    output logic [31:0]         o_stat_lookups,
    output logic [31:0]         o_stat_writes
`endif
);

    localparam int PTR_W  = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
    localparam int QCNT_W = $clog2(WQ_DEPTH + 1);
    localparam int SCNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [QCNT_W-1:0] Q_FULL     = QCNT_W'(WQ_DEPTH);
    localparam logic [SCNT_W-1:0] STARVE_LIM = SCNT_W'(STARVE_MAX);

    logic [IDX_W-1:0]    r_wqAddr [WQ_DEPTH];
    logic [ACTION_W-1:0] r_wqData [WQ_DEPTH];
    logic [PTR_W-1:0]    r_wrPtr;
    logic [PTR_W-1:0]    r_rdPtr;
    logic [QCNT_W-1:0]   r_qCount;
    logic [SCNT_W-1:0]   r_starveCnt;
    logic [ACTION_W-1:0] r_default;
    logic [ACTION_W-1:0] r_defSnap;
    logic                r_hitQ;
    logic                r_rspValid;
    logic                r_ovf;

    logic w_qNonEmpty;
    logic w_qFull;
    logic w_force;
    logic w_lkGrant;
    logic w_wrGrant;
    logic w_push;
    logic w_drop;

    assign w_qNonEmpty = (r_qCount != '0);
    assign w_qFull     = (r_qCount == Q_FULL);
    assign w_force     = (r_starveCnt == STARVE_LIM) && w_qNonEmpty;

    // Grants are suppressed while reset is asserted so nothing queued can leak into the RAM.
    assign w_lkGrant = i_resetn && i_lk_valid && !w_force;
    assign w_wrGrant = i_resetn && w_qNonEmpty && (!i_lk_valid || w_force);

    // A full queue still accepts a push when the head is popped in the same cycle.
    assign w_push = i_cfg_wr_en && (!w_qFull || w_wrGrant);
    assign w_drop = i_cfg_wr_en && w_qFull && !w_wrGrant;

    assign o_lk_ready    = !w_force;
    assign o_ram_en      = w_lkGrant || w_wrGrant;
    assign o_ram_we      = w_wrGrant;
    assign o_ram_addr    = w_wrGrant ? r_wqAddr[r_rdPtr] : i_lk_idx;
    assign o_ram_wdata   = r_wqData[r_rdPtr];
    assign o_rsp_valid   = r_rspValid;
    assign o_rsp_action  = !r_rspValid ? '0 : (r_hitQ ? i_ram_rdata : r_defSnap);
    assign o_cfg_wq_full = w_qFull;
    assign o_cfg_ovf     = r_ovf;

    // Queue storage: payload only, no reset needed since occupancy is tracked separately.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_wqAddr[r_wrPtr] <= i_cfg_wr_addr;
            r_wqData[r_wrPtr] <= i_cfg_wr_data;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally as the depth is a power of two.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_qCount <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_wrGrant) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            unique case ({w_push, w_wrGrant})
                2'b10:   r_qCount <= r_qCount + QCNT_W'(1);
                2'b01:   r_qCount <= r_qCount - QCNT_W'(1);
                default: r_qCount <= r_qCount;
            endcase
        end
    end

    // Starvation counter: counts lookups that jumped a waiting write, saturating at the limit.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_starveCnt <= '0;
        end else if (w_wrGrant || !w_qNonEmpty) begin
            r_starveCnt <= '0;
        end else if (w_lkGrant && (r_starveCnt != STARVE_LIM)) begin
            r_starveCnt <= r_starveCnt + SCNT_W'(1);
        end
    end

    // Lookup response pipeline: capture hit flag and the default as it stood at grant.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_rspValid <= 1'b0;
            r_hitQ     <= 1'b0;
            r_defSnap  <= '0;
        end else begin
            r_rspValid <= w_lkGrant;
            if (w_lkGrant) begin
                r_hitQ    <= i_lk_hit;
                r_defSnap <= r_default;
            end
        end
    end

    // Default action register and sticky overflow flag; a drop beats a clear in the same cycle.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_default <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (i_cfg_wr_default) begin
                r_default <= i_cfg_default_data;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (i_cfg_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef ACTION_ARB_STATS_EN
    logic [31:0] r_statLookups;
    logic [31:0] r_statWrites;

    assign o_stat_lookups = r_statLookups;
    assign o_stat_writes  = r_statWrites;

    // Free-running grant counters that wrap at 2^32.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_statLookups <= '0;
            r_statWrites  <= '0;
        end else begin
            if (w_lkGrant) begin
                r_statLookups <= r_statLookups + 32'd1;
            end
            if (w_wrGrant) begin
                r_statWrites <= r_statWrites + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_action_table_arbiter.sv
// tb_action_table_arbiter
//   Directed bench for action_table_arbiter with a queue-based reference
//   model compared every cycle, plus hand-computed literal expectations.
//   Connects the statistics ports when ACTION_ARB_STATS_EN is defined.
module tb_action_table_arbiter;

    localparam int ENTRIES    = 16;
    localparam int ACTION_W   = 64;
    localparam int IDX_W      = 4;
    localparam int WQ_DEPTH   = 4;
    localparam int STARVE_MAX = 8;

    typedef struct packed {
        logic [IDX_W-1:0]    addr;
        logic [ACTION_W-1:0] data;
    } wrEntry_t;

    logic                clk = 1'b0;
    logic                resetn;
    logic                lkValid;
    logic                lkReady;
    logic [IDX_W-1:0]    lkIdx;
    logic                lkHit;
    logic                rspValid;
    logic [ACTION_W-1:0] rspAction;
    logic                cfgWrEn;
    logic [IDX_W-1:0]    cfgWrAddr;
    logic [ACTION_W-1:0] cfgWrData;
    logic                cfgWrDefault;
    logic [ACTION_W-1:0] cfgDefaultData;
    logic                cfgWqFull;
    logic                cfgOvf;
    logic                cfgOvfClr;
    logic                ramEn;
    logic                ramWe;
    logic [IDX_W-1:0]    ramAddr;
    logic [ACTION_W-1:0] ramWdata;
    logic [ACTION_W-1:0] ramRdata;
`ifdef ACTION_ARB_STATS_EN
    logic [31:0]         statLookups;
    logic [31:0]         statWrites;
    int                  mLkCount;
    int                  mWrCount;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    logic [ACTION_W-1:0] ramMem [ENTRIES];

    // Reference model state
    wrEntry_t            mQueue[$];
    int                  mStarve;
    logic [ACTION_W-1:0] mDefault;
    logic [ACTION_W-1:0] mMem [ENTRIES];
    bit                  mOvf;
    bit                  mRspValid;
    logic [ACTION_W-1:0] mRsp;
    bit                  mReady = 1'b0;

    always #5 clk = ~clk;

    action_table_arbiter #(
        .ENTRIES(ENTRIES), .ACTION_W(ACTION_W), .IDX_W(IDX_W),
        .WQ_DEPTH(WQ_DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .i_clk(clk),
        .i_resetn(resetn),
        .i_lk_valid(lkValid),
        .o_lk_ready(lkReady),
        .i_lk_idx(lkIdx),
        .i_lk_hit(lkHit),
        .o_rsp_valid(rspValid),
        .o_rsp_action(rspAction),
        .i_cfg_wr_en(cfgWrEn),
        .i_cfg_wr_addr(cfgWrAddr),
        .i_cfg_wr_data(cfgWrData),
        .i_cfg_wr_default(cfgWrDefault),
        .i_cfg_default_data(cfgDefaultData),
        .o_cfg_wq_full(cfgWqFull),
        .o_cfg_ovf(cfgOvf),
        .i_cfg_ovf_clr(cfgOvfClr),
        .o_ram_en(ramEn),
        .o_ram_we(ramWe),
        .o_ram_addr(ramAddr),
        .o_ram_wdata(ramWdata),
        .i_ram_rdata(ramRdata)
`ifdef ACTION_ARB_STATS_EN
        ,
        .o_stat_lookups(statLookups),
        .o_stat_writes(statWrites)
`endif
    );

    function automatic logic [ACTION_W-1:0] preload(input int i);
        return (i == 3) ? 64'hAAAA_AAAA_AAAA_AAAA : (64'hC0DE_0000_0000_0000 | 64'(i));
    endfunction

    task automatic checkOutput(input string name, input logic [ACTION_W-1:0] actual,
                               input logic [ACTION_W-1:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit lkV, input logic [IDX_W-1:0] idx, input bit hit,
                                 input bit wrEn, input logic [IDX_W-1:0] wrA,
                                 input logic [ACTION_W-1:0] wrD, input bit wrDef,
                                 input logic [ACTION_W-1:0] defD, input bit clr);
        lkValid        = lkV;
        lkIdx          = idx;
        lkHit          = hit;
        cfgWrEn        = wrEn;
        cfgWrAddr      = wrA;
        cfgWrData      = wrD;
        cfgWrDefault   = wrDef;
        cfgDefaultData = defD;
        cfgOvfClr      = clr;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One lookup cycle then one idle cycle; checks the response literal.
    task automatic lookupExpect(input string name, input logic [IDX_W-1:0] idx, input bit hit,
                                input logic [ACTION_W-1:0] expected);
        applyStimulus(1'b1, idx, hit, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        step();
        idle();
        @(negedge clk);
        checkOutput({name, "_valid"}, 64'(rspValid), 64'd1);
        checkOutput(name, rspAction, expected);
        step();
    endtask

    // Single-port synchronous RAM behind the arbiter
    initial begin
        for (int i = 0; i < ENTRIES; i++) ramMem[i] = preload(i);
        forever begin
            @(posedge clk);
            if (ramEn) begin
                if (ramWe) ramMem[ramAddr] <= ramWdata;
                else       ramRdata <= ramMem[ramAddr];
            end
        end
    end

    // Reference model: predicts every output from the arbitration rules, then advances.
    initial begin
        bit       nonEmpty, forceW, lkG, wrG, dropped;
        wrEntry_t head;
        for (int i = 0; i < ENTRIES; i++) mMem[i] = preload(i);
        forever begin
            @(negedge clk);
            if (!resetn) begin
                checkOutput("ram_en_in_reset", 64'(ramEn), 64'd0);
                mQueue.delete();
                mStarve   = 0;
                mDefault  = '0;
                mOvf      = 1'b0;
                mRspValid = 1'b0;
                mReady    = 1'b1;
`ifdef ACTION_ARB_STATS_EN
                mLkCount  = 0;
                mWrCount  = 0;
`endif
            end else if (mReady) begin
                nonEmpty = (mQueue.size() != 0);
                forceW   = (mStarve == STARVE_MAX) && nonEmpty;
                lkG      = lkValid && !forceW;
                wrG      = nonEmpty && !lkG;
                head     = nonEmpty ? mQueue[0] : '0;

                checkOutput("lk_ready", 64'(lkReady), 64'(!forceW));
                checkOutput("ram_en", 64'(ramEn), 64'(lkG || wrG));
                checkOutput("ram_we", 64'(ramWe), 64'(wrG));
                if (lkG || wrG)
                    checkOutput("ram_addr", 64'(ramAddr), 64'(wrG ? head.addr : lkIdx));
                if (wrG)
                    checkOutput("ram_wdata", ramWdata, head.data);
                checkOutput("rsp_valid", 64'(rspValid), 64'(mRspValid));
                if (mRspValid)
                    checkOutput("rsp_action", rspAction, mRsp);
                checkOutput("wq_full", 64'(cfgWqFull), 64'(mQueue.size() == WQ_DEPTH));
                checkOutput("cfg_ovf", 64'(cfgOvf), 64'(mOvf));

                mRspValid = lkG;
                if (lkG) mRsp = lkHit ? mMem[lkIdx] : mDefault;
                if (wrG) begin
                    mMem[head.addr] = head.data;
                    void'(mQueue.pop_front());
                end
`ifdef ACTION_ARB_STATS_EN
                if (lkG) mLkCount++;
                if (wrG) mWrCount++;
`endif
                if (wrG || !nonEmpty)                   mStarve = 0;
                else if (lkG && mStarve < STARVE_MAX)   mStarve++;
                dropped = 1'b0;
                if (cfgWrEn) begin
                    if (mQueue.size() < WQ_DEPTH) mQueue.push_back('{addr: cfgWrAddr, data: cfgWrData});
                    else dropped = 1'b1;
                end
                if (dropped)        mOvf = 1'b1;
                else if (cfgOvfClr) mOvf = 1'b0;
                if (cfgWrDefault) mDefault = cfgDefaultData;
            end
        end
    end

    // Directed stimulus with literal expectations
    initial begin
        int          grants;
        logic [IDX_W-1:0] t6Addr [3];
        t6Addr = '{4'd1, 4'd2, 4'd4};
        resetn = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // Reset state
        @(negedge clk);
        checkOutput("reset_rsp_valid", 64'(rspValid), 64'd0);
        checkOutput("reset_rsp_action", rspAction, 64'd0);
        checkOutput("reset_ovf", 64'(cfgOvf), 64'd0);
        checkOutput("reset_wq_full", 64'(cfgWqFull), 64'd0);
        checkOutput("reset_lk_ready", 64'(lkReady), 64'd1);
        step();

        // Test 1: hit lookup with idle queue
        applyStimulus(1'b1, 4'd3, 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("t1_ram_en", 64'(ramEn), 64'd1);
        checkOutput("t1_ram_addr", 64'(ramAddr), 64'd3);
        step();
        idle();
        @(negedge clk);
        checkOutput("t1_rsp_valid", 64'(rspValid), 64'd1);
        checkOutput("t1_rsp_action", rspAction, 64'hAAAA_AAAA_AAAA_AAAA);
        step();

        // Test 2: miss returns default; same-cycle default update returns the old one
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 64'h1234, 1'b0);
        @(negedge clk);
        step();
        lookupExpect("t2_miss_default", 4'd3, 1'b0, 64'h1234);
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, '0, '0, 1'b1, 64'h9999, 1'b0);
        @(negedge clk);
        step();
        idle();
        @(negedge clk);
        checkOutput("t2_old_default", rspAction, 64'h1234);
        step();
        lookupExpect("t2_new_default", 4'd3, 1'b0, 64'h9999);

        // Test 3: queued write reaches the RAM one cycle later
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'd5, 64'h55, 1'b0, '0, 1'b0);
        @(negedge clk);
        step();
        idle();
        @(negedge clk);
        checkOutput("t3_ram_we", 64'(ramWe), 64'd1);
        checkOutput("t3_ram_addr", 64'(ramAddr), 64'd5);
        checkOutput("t3_ram_wdata", ramWdata, 64'h55);
        step();
        lookupExpect("t3_readback", 4'd5, 1'b1, 64'h55);

        // Test 4: starvation limit forces one write through
        applyStimulus(1'b1, 4'd0, 1'b1, 1'b1, 4'd7, 64'h77, 1'b0, '0, 1'b0);
        @(negedge clk);
        step();
        applyStimulus(1'b1, 4'd0, 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        grants = 0;
        for (int k = 0; k < STARVE_MAX; k++) begin
            @(negedge clk);
            if (lkReady && ramEn && !ramWe) grants++;
            step();
        end
        checkOutput("t4_grants_before_force", 64'(grants), 64'd8);
        @(negedge clk);
        checkOutput("t4_forced_ready", 64'(lkReady), 64'd0);
        checkOutput("t4_forced_we", 64'(ramWe), 64'd1);
        checkOutput("t4_forced_addr", 64'(ramAddr), 64'd7);
        step();
        @(negedge clk);
        checkOutput("t4_resume_ready", 64'(lkReady), 64'd1);
        step();
        idle();
        @(negedge clk);
        step();

        // Test 5: overflow with lookups saturating the port
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 4'd0, 1'b1, 1'b1, IDX_W'(10 + k), 64'hA0 + 64'(k), 1'b0, '0, 1'b0);
            @(negedge clk);
            step();
        end
        applyStimulus(1'b1, 4'd0, 1'b1, 1'b1, 4'd14, 64'hA4, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("t5_full_after_4", 64'(cfgWqFull), 64'd1);
        checkOutput("t5_ovf_before_drop", 64'(cfgOvf), 64'd0);
        step();
        applyStimulus(1'b1, 4'd0, 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("t5_ovf_set", 64'(cfgOvf), 64'd1);
        step();
        applyStimulus(1'b1, 4'd0, 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        @(negedge clk);
        step();
        applyStimulus(1'b1, 4'd0, 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        step();
        applyStimulus(1'b1, 4'd0, 1'b1, 1'b1, 4'd15, 64'hA5, 1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("t5_ovf_cleared", 64'(cfgOvf), 64'd0);
        step();
        applyStimulus(1'b1, 4'd0, 1'b1, 1'b1, 4'd9, 64'h99, 1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("t5_set_wins", 64'(cfgOvf), 64'd1);
        checkOutput("t5_force_ready", 64'(lkReady), 64'd0);
        step();
        applyStimulus(1'b1, 4'd0, 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("t5_clr_after_accept", 64'(cfgOvf), 64'd0);
        checkOutput("t5_full_pop_push", 64'(cfgWqFull), 64'd1);
        step();
        idle();
        repeat (5) begin
            @(negedge clk);
            step();
        end
        @(negedge clk);
        checkOutput("t5_drained", 64'(cfgWqFull), 64'd0);
        step();
        lookupExpect("t5_pushed_on_pop", 4'd9, 1'b1, 64'h99);
        lookupExpect("t5_dropped_not_written", 4'd14, 1'b1, 64'hC0DE_0000_0000_000E);

        // Test 6: reset with queued writes and a lookup in flight
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 4'd0, 1'b1, 1'b1, t6Addr[k], 64'hDEAD_0000 + 64'(k), 1'b0, '0, 1'b0);
            @(negedge clk);
            step();
        end
        applyStimulus(1'b1, 4'd6, 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        step();
        idle();
        resetn = 1'b0;
        @(negedge clk);
        checkOutput("t6_no_write_in_reset", 64'(ramWe), 64'd0);
        step();
        @(negedge clk);
        step();
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("t6_rsp_valid", 64'(rspValid), 64'd0);
        checkOutput("t6_wq_full", 64'(cfgWqFull), 64'd0);
        checkOutput("t6_ram_idle", 64'(ramEn), 64'd0);
        step();
        repeat (3) begin
            @(negedge clk);
            step();
        end
        for (int k = 0; k < 3; k++)
            lookupExpect("t6_ram_untouched", t6Addr[k], 1'b1,
                         64'hC0DE_0000_0000_0000 | 64'(t6Addr[k]));
        lookupExpect("t6_default_cleared", 4'd3, 1'b0, 64'd0);

`ifdef ACTION_ARB_STATS_EN
        @(negedge clk);
        checkOutput("stat_lookups", 64'(statLookups), 64'(mLkCount));
        checkOutput("stat_writes", 64'(statWrites), 64'(mWrCount));
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
